beat_sequencer: RTL
===================

Name: beat_sequencer

Overview:
- Upstream stage of the noise decider and the note/tone lookups: produces the 12-bit beat index `ibeatNum` that they decode.
- Handles tempo timing, play/pause/stop and song looping, so every decoder downstream stays purely combinational.
- Sits between the debounced one-pulse button logic and the decoders that drive the audio path.

Parameters:
- BEAT_DIV, 12_500_000, clk cycles per beat (8 beats/s at 100 MHz); must be >= 2.
- LEN, 64, song length in beats; ibeatNum spans 0..LEN-1; must satisfy 2 <= LEN <= 4096.
- BEAT_W, 12, width of ibeatNum.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- play_pause  in  1  one-cycle pulse; toggles play/pause, or starts from stopped
- stop  in  1  one-cycle pulse; return to stopped at beat 0
- loop_en  in  1  level; when 1, the song wraps instead of ending
- ibeatNum  out  BEAT_W  current beat index (registered)
- beat_tick  out  1  one-cycle pulse in the cycle ibeatNum takes a new value while playing
- playing  out  1  1 while in PLAY
- song_done  out  1  one-cycle pulse when the last beat completes

Behaviour:
- All outputs registered. On rst (sampled at a clk edge): state=IDLE, div_cnt=0, ibeatNum=0, beat_tick=0, playing=0, song_done=0. rst overrides all inputs.
- States:
  - IDLE: ibeatNum=0, div_cnt=0.
  - PLAY: prescaler runs.
  - PAUSE: div_cnt and ibeatNum hold.
- Prescaler: div_cnt, width clog2(BEAT_DIV). In PLAY, each edge:
  - if div_cnt==BEAT_DIV-1, then div_cnt<=0 and the beat advances;
  - otherwise div_cnt increments.
- Advance:
  - ibeatNum<LEN-1: ibeatNum+1, beat_tick=1.
  - ibeatNum==LEN-1, loop_en=1: ibeatNum<=0, beat_tick=1, song_done=1, stay in PLAY.
  - ibeatNum==LEN-1, loop_en=0: go to IDLE, ibeatNum<=0, song_done=1, beat_tick=0, playing<=0.
  - loop_en is sampled only on the advance cycle.
- Transitions (priority: rst > stop > play_pause > advance):
  - stop, any state -> IDLE, ibeatNum=0, div_cnt=0, no song_done.
  - play_pause in IDLE -> PLAY with div_cnt=0. First advance happens at the BEAT_DIV-th edge after the edge that sampled play_pause.
  - play_pause in PLAY -> PAUSE. This overrides an advance due on the same edge: no advance, div_cnt holds, beat_tick=0.
  - play_pause in PAUSE -> PLAY. div_cnt resumes from its held value, so the beat continues mid-beat.
- playing reflects the next state (1 exactly while state==PLAY).
- beat_tick and song_done are never high outside the single cycle following the advancing edge.
- Counter arithmetic is unsigned. ibeatNum never exceeds LEN-1.

Decomposition:
- Shared package player_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_PLAY=2'd1, ST_PAUSE=2'd2;
  - BEAT_W=12;
  - default song LEN=64 (also used by noise_decider and the tone tables).
- One sub-module, beat_prescaler:
  - inputs: enable, clear;
  - outputs: div_cnt and a tick asserted when div_cnt==BEAT_DIV-1 && enable.
- The FSM and ibeatNum register live in beat_sequencer.

Test Plan (bench params BEAT_DIV=4, LEN=8):
- Reset, then play_pause sampled at edge 0 -> playing=1 after edge 0; ibeatNum=1 with beat_tick=1 after edge 4; ibeatNum=2 after edge 8; beat_tick low on all other cycles.
- Play, pause when div_cnt=2, hold 10 cycles, resume -> ibeatNum unchanged during pause; next advance exactly 2 edges after the resume edge.
- loop_en=0, run from start -> ibeatNum 0..7; at the edge after beat 7 completes: song_done=1, beat_tick=0, playing=0, ibeatNum=0, state IDLE.
- loop_en=1 -> ibeatNum 7->0 with beat_tick=1 and song_done=1 on the same cycle; playing stays 1; next advance to 1 after 4 edges.
- In PLAY at ibeatNum=5, stop and play_pause on the same edge -> IDLE, ibeatNum=0, playing=0, song_done=0. Then play_pause -> playback restarts at beat 0.
- rst asserted at ibeatNum=3 mid-beat, with play_pause pulsed during rst -> all outputs 0 after the edge and state IDLE; after rst drops, ibeatNum stays 0 until a new play_pause.

Source files
------------

// File: rtl/player_pkg.sv
// player_pkg
//   Shared definitions for the music player datapath: FSM state encoding of
//   the beat sequencer, default beat-index width and default song length
//   (the song length is also used by the noise decider and tone tables).
package player_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam int DEFAULT_BEAT_W = 12;
  localparam int DEFAULT_LEN    = 64;

endpackage

// File: rtl/beat_prescaler.sv
// beat_prescaler
//   Divides clk down to the beat rate. div_cnt counts 0..BEAT_DIV-1 while
//   enabled, holds while disabled, and is forced to 0 by clear or rst.
//   Ports:
//     clk, rst  : clock, synchronous active-high reset
//     enable    : count this cycle
//     clear     : force div_cnt to 0 (wins over enable)
//     div_cnt   : current prescaler count (registered)
//     tick      : combinational, high when the count wraps this edge
module beat_prescaler #(
  parameter int BEAT_DIV = 12_500_000,
  parameter int DIV_W    = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             clear,
  output logic [DIV_W-1:0] div_cnt,
  output logic             tick
);

  logic [DIV_W-1:0] div_cnt_q;
  logic [DIV_W-1:0] div_cnt_d;

  assign tick    = enable && (div_cnt_q == DIV_W'(BEAT_DIV - 1));
  assign div_cnt = div_cnt_q;

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (clear) begin
      div_cnt_d = '0;
    end else if (enable) begin
      div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/beat_sequencer.sv
// beat_sequencer
//   Tempo timing and transport control (play/pause/stop, looping) producing
//   the registered beat index consumed by the note/tone/noise decoders.
//   Ports:
//     clk, rst    : clock, synchronous active-high reset
//     play_pause  : one-cycle pulse, start from stopped or toggle play/pause
//     stop        : one-cycle pulse, return to stopped at beat 0
//     loop_en     : level, wrap the song instead of ending it
//     ibeatNum    : current beat index, 0..LEN-1 (registered)
//     beat_tick   : pulse in the cycle ibeatNum takes a new value while playing
//     playing     : 1 while in PLAY (registered)
//     song_done   : pulse when the last beat completes
module beat_sequencer
  import player_pkg::*;
#(
  parameter int BEAT_DIV = 12_500_000,
  parameter int LEN      = DEFAULT_LEN,
  parameter int BEAT_W   = DEFAULT_BEAT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              play_pause,
  input  logic              stop,
  input  logic              loop_en,
  output logic [BEAT_W-1:0] ibeatNum,
  output logic              beat_tick,
  output logic              playing,
  output logic              song_done
);

  localparam int DIV_W = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;

  state_t            state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              beat_tick_q, beat_tick_d;
  logic              playing_q, playing_d;
  logic              song_done_q, song_done_d;

  logic              pre_enable;
  logic              pre_clear;
  logic              advance;
  logic              last_beat;
  logic [DIV_W-1:0]  div_cnt;

  // The prescaler only runs on edges where PLAY continues undisturbed; a
  // play_pause or stop on the same edge freezes (or clears) it, which is
  // what makes a pause override an advance that was due on that edge.
  assign pre_enable = (state_q == ST_PLAY) && !stop && !play_pause;
  assign pre_clear  = stop || (state_q == ST_IDLE);
  assign last_beat  = (beat_q == BEAT_W'(LEN - 1));

  beat_prescaler #(
    .BEAT_DIV (BEAT_DIV),
    .DIV_W    (DIV_W)
  ) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .enable  (pre_enable),
    .clear   (pre_clear),
    .div_cnt (div_cnt),
    .tick    (advance)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      beat_q      <= '0;
      beat_tick_q <= 1'b0;
      playing_q   <= 1'b0;
      song_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      beat_tick_q <= beat_tick_d;
      playing_q   <= playing_d;
      song_done_q <= song_done_d;
    end
  end

  // Next-state logic (stop > play_pause > advance)
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    if (stop) begin
      state_d = ST_IDLE;
      beat_d  = '0;
    end else if (play_pause) begin
      case (state_q)
        ST_IDLE:  state_d = ST_PLAY;
        ST_PLAY:  state_d = ST_PAUSE;
        ST_PAUSE: state_d = ST_PLAY;
        default:  state_d = ST_IDLE;
      endcase
    end else if (advance) begin
      if (!last_beat) begin
        beat_d = beat_q + BEAT_W'(1);
      end else begin
        beat_d = '0;
        if (!loop_en) begin
          state_d = ST_IDLE;
        end
      end
    end
  end

  // Output logic, registered alongside the state
  always_comb begin
    beat_tick_d = 1'b0;
    song_done_d = 1'b0;
    playing_d   = (state_d == ST_PLAY);
    if (advance) begin
      song_done_d = last_beat;
      beat_tick_d = !last_beat || loop_en;
    end
  end

  assign ibeatNum  = beat_q;
  assign beat_tick = beat_tick_q;
  assign playing   = playing_q;
  assign song_done = song_done_q;

endmodule
